seq_multiplier: RTL and testbench

Sequential unsigned shift-add multiplier on the datapath's multiply path, directly downstream of the instruction decoder. It is started by the decoder's multiplier-start bit, which is held at level for the whole MUL instruction, and it multiplies the two register-file operands (rs, rt). Its product feeds channel 1 of the ALU/multiplier result mux. It exposes busy/done so the pipeline can stall until the product is valid.

---
 rtl/seq_multiplier.sv | 87 ++++++++
 tb/tb_seq_multiplier.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier: one partial product per RUN cycle,
// fixed WIDTH-cycle latency, result held in HOLD until the start level drops.
module seq_multiplier #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   operandA,
  input  logic [WIDTH-1:0]   operandB,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t               state_q,   state_d;
  logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]     mplier_q,  mplier_d;
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   sum;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    // Multiplicand is zero-extended, so the running sum never exceeds 2*WIDTH bits.
    sum       = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, operandA};
          mplier_d = operandB;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = sum;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        // Waiting for start to drop keeps a held decoder level from retriggering.
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == HOLD);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: latency, hold/re-arm, operand capture and
// mid-run reset, with hand-computed products.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] operandA;
  logic [15:0] operandB;
  logic [31:0] product;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  seq_multiplier #(.WIDTH(16), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .operandA (operandA),
    .operandB (operandB),
    .product  (product),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an op from IDLE and samples each negedge until busy falls.
  // Returns at the negedge where the result should be visible.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string tag, input bit drop_early);
    int cyc;
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_done"}, done, 0);
    start = 1'b1; operandA = a; operandB = b;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 100) begin
      chk({tag, "_no_done_in_run"}, done, 0);
      cyc++;
      if (drop_early && cyc == 3) begin
        operandA = 16'hAAAA; operandB = 16'h5555; start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, cyc, 16);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_product"}, product, exp);
  endtask

  initial begin
    int busy_seen;
    rst = 1'b1; start = 1'b0; operandA = '0; operandB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // 3*5 with start held: done must persist.
    run_op(16'd3, 16'd5, 32'h0000000F, "mul3x5", 1'b0);
    repeat (3) @(negedge clk);
    chk("mul3x5_done_held", done, 1);
    chk("mul3x5_busy_held", busy, 0);
    start = 1'b0;
    @(negedge clk);
    chk("mul3x5_done_fall", done, 0);
    chk("mul3x5_product_kept", product, 32'h0000000F);

    // Max operands, then a 40-cycle hold with no retrigger.
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "mulmax", 1'b0);
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("hold40_no_busy", busy_seen, 0);
    chk("hold40_done", done, 1);
    chk("hold40_product", product, 32'hFFFE0001);
    start = 1'b0;

    run_op(16'd2, 16'd4, 32'd8, "mul2x4", 1'b0);
    start = 1'b0;

    run_op(16'h1234, 16'h0000, 32'd0, "mulzero", 1'b0);
    start = 1'b0;

    // Operands changed and start dropped during RUN: original operands used.
    run_op(16'd7, 16'd9, 32'd63, "mul7x9_drop", 1'b1);
    @(negedge clk);
    chk("mul7x9_done_pulse", done, 0);
    chk("mul7x9_no_restart", busy, 0);

    // Reset during RUN cycle 8 of 100*200.
    @(negedge clk);
    start = 1'b1; operandA = 16'd100; operandB = 16'd200;
    @(posedge clk);
    repeat (8) @(negedge clk);
    chk("rstmid_busy_before", busy, 1);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_product", product, 0);
    rst = 1'b0;

    run_op(16'd10, 16'd20, 32'd200, "mul10x20", 1'b0);
    start = 1'b0;

    // Back-to-back with a single start-low cycle between them.
    run_op(16'd5, 16'd6, 32'd30, "b2b_first", 1'b0);
    start = 1'b0;
    run_op(16'd11, 16'd13, 32'd143, "b2b_second", 1'b0);
    start = 1'b0;
    @(negedge clk);
    chk("final_idle_done", done, 0);
    chk("final_product", product, 32'd143);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
